// File: rtl/cpu_run_control_if.sv
// Host/core-side signal bundle of the run controller.
// The controller takes the slave view; the host or testbench takes the master view.
interface cpu_run_control_if #(
    parameter int CYC_W = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [CYC_W-1:0] run_len;
    logic             step;
    logic             abort;
    logic [31:0]      pc_in;
    logic [31:0]      instr_in;
    logic             cpu_en;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CYC_W-1:0] cycle_count;

    modport master (
        output start,
        output mode,
        output run_len,
        output step,
        output abort,
        output pc_in,
        output instr_in,
        input  cpu_en,
        input  cpu_rst_n,
        input  busy,
        input  done,
        input  status,
        input  cycle_count
    );

    modport slave (
        input  start,
        input  mode,
        input  run_len,
        input  step,
        input  abort,
        input  pc_in,
        input  instr_in,
        output cpu_en,
        output cpu_rst_n,
        output busy,
        output done,
        output status,
        output cycle_count
    );
endinterface

// File: rtl/cpu_run_control.sv
// Run controller for the processor core: clock-enable gating, core reset,
// free-run / single-step / run-N modes, halt detection and cycle watchdog.
module cpu_run_control #(
    parameter int              CYC_W       = 32,
    parameter longint unsigned MAX_CYCLES  = 10,
    parameter int              RST_CYCLES  = 2,
    parameter logic [5:0]      HALT_OPCODE = 6'b111111,
    parameter int              STALL_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    cpu_run_control_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_STEP  = 2'b01;
    localparam logic [1:0] M_RUN_N = 2'b10;

    localparam logic [1:0] ST_LEN   = 2'b00;
    localparam logic [1:0] ST_HALT  = 2'b01;
    localparam logic [1:0] ST_WDOG  = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(STALL_LIMIT + 2);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    // A watchdog limit beyond the counter range can never match.
    localparam longint unsigned CNT_MAX =
        (CYC_W >= 64) ? {64{1'b1}} : ((64'd1 << CYC_W) - 64'd1);
    localparam bit               WDOG_EN  = (MAX_CYCLES <= CNT_MAX);
    localparam logic [CYC_W-1:0] WDOG_CNT = CYC_W'(MAX_CYCLES);

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [CYC_W-1:0] len_q;
    logic [CYC_W-1:0] len_d;
    logic [SW-1:0]    stall_q;
    logic [SW-1:0]    stall_d;
    logic [31:0]      last_pc;
    logic [31:0]      last_pc_d;
    logic [RW-1:0]    rst_cnt;
    logic [RW-1:0]    rst_cnt_d;
    logic             en_q;
    logic             en_d;
    logic             crst_q;
    logic             crst_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic [1:0]       status_q;
    logic [1:0]       status_d;
    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    logic [CYC_W-1:0] count_inc;
    logic [SW-1:0]    stall_inc;
    logic             halt_hit;
    logic             wdog_hit;
    logic             len_hit;
    logic             term;
    logic [1:0]       term_code;
    logic             fin;
    logic [1:0]       fin_code;

    // Termination is judged on the post-increment count of the enabled cycle.
    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + CYC_W'(1);
        stall_inc = '0;
        if (bus.pc_in == last_pc) begin
            stall_inc = (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
        end
        halt_hit = (bus.instr_in[31:26] == HALT_OPCODE)
                || (stall_inc == STALL_MAX);
        wdog_hit = WDOG_EN && (count_inc == WDOG_CNT);
        len_hit  = (mode_q == M_RUN_N) && (count_inc == len_q);
        term     = bus.abort || halt_hit || wdog_hit || len_hit;
        if (bus.abort) begin
            term_code = ST_ABORT;
        end else if (halt_hit) begin
            term_code = ST_HALT;
        end else if (wdog_hit) begin
            term_code = ST_WDOG;
        end else begin
            term_code = ST_LEN;
        end
    end

    always_comb begin
        state_d   = state;
        mode_d    = mode_q;
        len_d     = len_q;
        stall_d   = stall_q;
        last_pc_d = last_pc;
        rst_cnt_d = rst_cnt;
        en_d      = en_q;
        crst_d    = crst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        status_d  = status_q;
        count_d   = count_q;
        fin       = 1'b0;
        fin_code  = ST_LEN;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    len_d     = bus.run_len;
                    count_d   = '0;
                    status_d  = ST_LEN;
                    stall_d   = '0;
                    rst_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    crst_d    = 1'b0;
                    en_d      = 1'b0;
                    state_d   = S_RESET;
                end
            end
            S_RESET: begin
                if (bus.abort) begin
                    fin      = 1'b1;
                    fin_code = ST_ABORT;
                end else if (rst_cnt == RST_LAST) begin
                    crst_d = 1'b1;
                    if (mode_q == M_STEP) begin
                        state_d = S_STEP;
                    end else if (mode_q == M_RUN_N && len_q == '0) begin
                        fin      = 1'b1;
                        fin_code = ST_LEN;
                    end else begin
                        state_d = S_RUN;
                        en_d    = 1'b1;
                    end
                end else begin
                    rst_cnt_d = rst_cnt + RW'(1);
                end
            end
            S_RUN, S_STEP: begin
                if (en_q) begin
                    count_d   = count_inc;
                    stall_d   = stall_inc;
                    last_pc_d = bus.pc_in;
                    if (term) begin
                        fin      = 1'b1;
                        fin_code = term_code;
                    end else if (state == S_STEP) begin
                        en_d = 1'b0;
                    end
                end else if (bus.abort) begin
                    fin      = 1'b1;
                    fin_code = ST_ABORT;
                end else if (state == S_STEP && bus.step) begin
                    en_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Core reset stays released in DONE so its state can be inspected.
        if (fin) begin
            state_d  = S_DONE;
            en_d     = 1'b0;
            crst_d   = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            status_d = fin_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            len_q    <= '0;
            stall_q  <= '0;
            last_pc  <= '0;
            rst_cnt  <= '0;
            en_q     <= 1'b0;
            crst_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_LEN;
            count_q  <= '0;
        end else begin
            state    <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            stall_q  <= stall_d;
            last_pc  <= last_pc_d;
            rst_cnt  <= rst_cnt_d;
            en_q     <= en_d;
            crst_q   <= crst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
            count_q  <= count_d;
        end
    end

    assign bus.cpu_en      = en_q;
    assign bus.cpu_rst_n   = crst_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Randomised self-checking bench for cpu_run_control against a
// per-enabled-cycle reference model of the termination rules.
module tb_cpu_run_control;

    localparam int CYC_W       = 32;
    localparam int MAX_N       = 10;
    localparam int RST_CYCLES  = 2;
    localparam int STALL_LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_control_if #(.CYC_W(CYC_W)) bus ();

    cpu_run_control #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (64'(MAX_N)),
        .RST_CYCLES (RST_CYCLES),
        .HALT_OPCODE(6'b111111),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus per enabled cycle: index k-1 is what the core sees on cycle k.
    logic [31:0] pcs   [16];
    logic [31:0] ins   [16];
    bit          abs_v [16];
    logic [31:0] model_last = '0;

    task automatic fill_seq(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            pcs[i]   = base + 32'(4 * i);
            ins[i]   = 32'h0000_0013;
            abs_v[i] = 1'b0;
        end
    endtask

    // Walk enabled cycles, apply the rules in priority order, stop at the first hit.
    function automatic void model(input logic [1:0] m, input logic [31:0] len,
                                  output int cnt, output logic [1:0] st);
        int          stall;
        logic [31:0] pc;
        stall = 0;
        cnt   = 0;
        st    = 2'b00;
        if (m == 2'b10 && len == 0) return;
        for (int k = 1; k <= 16; k++) begin
            pc         = pcs[k-1];
            stall      = (pc == model_last) ? stall + 1 : 0;
            model_last = pc;
            cnt        = k;
            if (abs_v[k-1]) begin
                st = 2'b11;
                return;
            end
            if (ins[k-1][31:26] == 6'b111111 || stall >= STALL_LIMIT) begin
                st = 2'b01;
                return;
            end
            if (k == MAX_N) begin
                st = 2'b10;
                return;
            end
            if (m == 2'b10 && 32'(k) == len) begin
                st = 2'b00;
                return;
            end
        end
    endfunction

    task automatic drive_run(input logic [1:0] m, input logic [31:0] len,
                             input bit start_mid,
                             output int rst_low, output int en_n,
                             output int idle_n, output logic first_done,
                             output logic [31:0] first_count, output bit timeout);
        rst_low = 0;
        en_n    = 0;
        idle_n  = 0;
        timeout = 1'b1;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.run_len = len;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mode    = 2'($urandom);
        bus.run_len = $urandom;
        first_done  = bus.done;
        first_count = bus.cycle_count;
        for (int c = 0; c < 60; c++) begin
            if (bus.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (bus.cpu_rst_n !== 1'b1) rst_low++;
            if (bus.busy !== 1'b1) idle_n++;
            bus.start = start_mid && (c == 4);
            if (bus.cpu_en === 1'b1) begin
                if (en_n < 16) begin
                    bus.pc_in    = pcs[en_n];
                    bus.instr_in = ins[en_n];
                    bus.abort    = abs_v[en_n];
                end
                en_n++;
            end else begin
                bus.instr_in = '0;
                bus.abort    = 1'b0;
            end
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.instr_in = '0;
    endtask

    task automatic test_reset;
        bus.start    = 1'b0;
        bus.mode     = 2'b00;
        bus.run_len  = '0;
        bus.step     = 1'b0;
        bus.abort    = 1'b0;
        bus.pc_in    = '0;
        bus.instr_in = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cpu_en, bus.cpu_rst_n, bus.busy, bus.done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected 0000",
                     {bus.cpu_en, bus.cpu_rst_n, bus.busy, bus.done});
        end
        checks++;
        if (bus.status !== 2'b00 || bus.cycle_count !== '0) begin
            failures++;
            $display("FAIL reset_cnt: got status %b count %0d expected 00 / 0",
                     bus.status, bus.cycle_count);
        end
        rst_n      = 1'b1;
        model_last = '0;
        @(negedge clk);
    endtask

    task automatic test_free_run;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_1000);
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to) begin failures++; $display("FAIL free_timeout: done never rose"); end
        checks++; if (rl != RST_CYCLES) begin failures++; $display("FAIL free_rst_low: got %0d expected %0d", rl, RST_CYCLES); end
        checks++; if (en != cnt) begin failures++; $display("FAIL free_en_cycles: got %0d expected %0d", en, cnt); end
        checks++; if (bus.cycle_count !== 32'(cnt)) begin failures++; $display("FAIL free_count: got %0d expected %0d", bus.cycle_count, cnt); end
        checks++; if (bus.status !== st) begin failures++; $display("FAIL free_status: got %b expected %b", bus.status, st); end
        checks++; if (idle != 0) begin failures++; $display("FAIL free_busy: got %0d idle cycles expected 0", idle); end
        checks++;
        if ({bus.cpu_en, bus.cpu_rst_n, bus.busy} !== 3'b010) begin
            failures++;
            $display("FAIL free_done_ctl: got %b expected 010", {bus.cpu_en, bus.cpu_rst_n, bus.busy});
        end
    endtask

    task automatic test_run_n;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_8000);
        model(2'b10, 32'd5, cnt, st);
        drive_run(2'b10, 32'd5, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || en != cnt) begin failures++; $display("FAIL runn5_en: got %0d expected %0d", en, cnt); end
        checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL runn5_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
        fill_seq(32'h0000_9000);
        model(2'b10, 32'd0, cnt, st);
        drive_run(2'b10, 32'd0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || en != 0 || rl != RST_CYCLES) begin failures++; $display("FAIL runn0_timing: got en %0d rst %0d expected 0 / %0d", en, rl, RST_CYCLES); end
        checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL runn0_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_halt_opcode;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_2000);
        ins[2] = 32'hFC00_0000;
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || en != cnt) begin failures++; $display("FAIL halt_en: got %0d expected %0d", en, cnt); end
        checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL halt_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_stall;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_3000);
        for (int i = 2; i < 16; i++) pcs[i] = pcs[1];
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || en != cnt) begin failures++; $display("FAIL stall_en: got %0d expected %0d", en, cnt); end
        checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL stall_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_step;
        int pulses, dbl, busy_low;
        logic prev_en;
        pulses   = 0;
        dbl      = 0;
        busy_low = 0;
        prev_en  = 1'b0;
        fill_seq(32'h0000_4000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (bus.cpu_en === 1'b1) begin
                if (prev_en) dbl++;
                bus.pc_in = pcs[pulses];
                pulses++;
            end
            if (bus.busy !== 1'b1) busy_low++;
            prev_en  = bus.cpu_en;
            bus.step = (c == 4) || (c == 7) || (c == 10) || (bus.cpu_en === 1'b1);
            @(negedge clk);
        end
        bus.step = 1'b0;
        checks++; if (pulses != 3 || dbl != 0) begin failures++; $display("FAIL step_pulses: got %0d (%0d wide) expected 3 (0 wide)", pulses, dbl); end
        checks++; if (busy_low != 0 || bus.done !== 1'b0) begin failures++; $display("FAIL step_busy: got %0d idle done %b expected 0 / 0", busy_low, bus.done); end
        checks++; if (bus.cycle_count !== 32'd3) begin failures++; $display("FAIL step_count: got %0d expected 3", bus.cycle_count); end
        model_last = pcs[2];
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.status !== 2'b11 || bus.cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL step_abort: got %b/%b/%0d expected 1/11/3", bus.done, bus.status, bus.cycle_count);
        end
    endtask

    task automatic test_abort;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_6000);
        ins[2]   = 32'hFC00_0000;
        abs_v[2] = 1'b1;
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL abort_halt: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
        fill_seq(32'h0000_7000);
        abs_v[9] = 1'b1;
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (to || bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL abort_wdog: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_start_in_run;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_A000);
        model(2'b00, '0, cnt, st);
        drive_run(2'b00, '0, 1'b1, rl, en, idle, fd, fc, to);
        checks++; if (to || rl != RST_CYCLES || en != cnt) begin failures++; $display("FAIL start_in_run: got rst %0d en %0d expected %0d / %0d", rl, en, RST_CYCLES, cnt); end
        checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL start_in_run_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_back_to_back;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        fill_seq(32'h0000_B000);
        model(2'b10, 32'd7, cnt, st);
        drive_run(2'b10, 32'd7, 1'b0, rl, en, idle, fd, fc, to);
        checks++; if (fd !== 1'b0 || fc !== '0) begin failures++; $display("FAIL b2b_restart: got done %b count %0d expected 0 / 0", fd, fc); end
        checks++; if (to || bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL b2b_result: got %0d/%b expected %0d/%b", bus.cycle_count, bus.status, cnt, st); end
    endtask

    task automatic test_random;
        int rl, en, idle, cnt;
        logic fd;
        logic [31:0] fc;
        bit to;
        logic [1:0] st;
        logic [1:0] m;
        logic [31:0] len;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0:       m = 2'b00;
                1:       m = 2'b10;
                default: m = 2'b11;
            endcase
            len    = 32'($urandom_range(0, 12));
            pcs[0] = $urandom & 32'hFFFF_FFFC;
            for (int i = 0; i < 16; i++) begin
                if (i > 0) pcs[i] = ($urandom_range(0, 2) == 0) ? pcs[i-1] : pcs[i-1] + 32'd4;
                ins[i]   = ($urandom_range(0, 11) == 0) ? (32'hFC00_0000 | ($urandom & 32'h03FF_FFFF)) : $urandom;
                abs_v[i] = ($urandom_range(0, 19) == 0);
            end
            model(m, len, cnt, st);
            drive_run(m, len, 1'b0, rl, en, idle, fd, fc, to);
            checks++; if (to || en != cnt || rl != RST_CYCLES) begin failures++; $display("FAIL rand%0d_timing: got en %0d rst %0d expected %0d / %0d", it, en, rl, cnt, RST_CYCLES); end
            checks++; if (bus.cycle_count !== 32'(cnt) || bus.status !== st) begin failures++; $display("FAIL rand%0d_result: got %0d/%b expected %0d/%b", it, bus.cycle_count, bus.status, cnt, st); end
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.pc_in = 32'h0000_C000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            bus.pc_in = bus.pc_in + 32'd4;
            @(negedge clk);
        end
        checks++; if (bus.cpu_en !== 1'b1) begin failures++; $display("FAIL midrun_running: got cpu_en %b expected 1", bus.cpu_en); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cpu_en, bus.cpu_rst_n, bus.busy, bus.done, bus.status} !== 6'b0 || bus.cycle_count !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got %b count %0d expected 000000 / 0",
                     {bus.cpu_en, bus.cpu_rst_n, bus.busy, bus.done, bus.status}, bus.cycle_count);
        end
        rst_n      = 1'b1;
        model_last = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_run_n();
        test_halt_opcode();
        test_stall();
        test_step();
        test_abort();
        test_start_in_run();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
